serial_code_converter: RTL and testbench

//  Parametrised bit-serial, LSB-first digit code converter: subtracts (Excess-3 -> BCD)
//  or adds (BCD -> Excess-3) a constant OFFSET on NBITS-bit digits streamed one bit per

---
 rtl/serial_code_converter.sv | 145 ++++++++++++++
 tb/tb_serial_code_converter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_code_converter.sv
// serial_code_converter: bit-serial, LSB-first digit converter that adds
// (BCD -> Excess-3) or subtracts (Excess-3 -> BCD) a constant OFFSET on
// NBITS-bit digits. It checks each digit against the legal code range and
// presents the converted digit in parallel one cycle after its last bit.
// Optional feature macro: CONV_REG_OUT_EN registers the serial output Z.
// When it is defined, Z appears one enabled bit later.
module serial_code_converter #(
  parameter int unsigned NBITS  = 4,
  parameter int unsigned OFFSET = 3,
  parameter int unsigned RANGE  = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Mode,
  input  logic             X,
  output logic             Z,
  output logic             DigitDone,
  output logic [NBITS-1:0] Dout,
  output logic             Err
);

  localparam int unsigned CW = $clog2(NBITS);
  localparam int unsigned SW = NBITS - 1;

  localparam logic [NBITS-1:0] OFF_V  = NBITS'(OFFSET);
  localparam logic [NBITS-1:0] HI_V   = NBITS'(OFFSET + RANGE - 1);
  localparam logic [NBITS-1:0] RMAX_V = NBITS'(RANGE - 1);
  localparam logic [CW-1:0]    LAST   = CW'(NBITS - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             mode_q, mode_d;
  logic [SW-1:0]    in_sh_q, in_sh_d;
  logic [SW-1:0]    out_sh_q, out_sh_d;
  logic             done_q, done_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             err_q, err_d;

  logic             first;
  logic             fire;
  logic             m_eff;
  logic             c_eff;
  logic             k_bit;
  logic             z_raw;
  logic             cy_next;
  logic [NBITS-1:0] in_full;
  logic [NBITS-1:0] out_full;

  // Per-bit datapath: effective mode/carry, serial sum/difference bit, next carry.
  always_comb begin
    first    = (cnt_q == '0);
    fire     = Rst & En;
    m_eff    = first ? Mode : mode_q;
    c_eff    = first ? 1'b0 : cy_q;
    k_bit    = OFF_V[cnt_q];
    z_raw    = X ^ k_bit ^ c_eff;
    if (m_eff) begin
      cy_next = (~X & k_bit) | (c_eff & ~(X ^ k_bit));
    end else begin
      cy_next = (X & k_bit) | (c_eff & (X ^ k_bit));
    end
    in_full  = {X, in_sh_q};
    out_full = {z_raw, out_sh_q};
  end

  // Next-state: advance one bit on enabled cycles; DigitDone is a one-cycle pulse.
  always_comb begin
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    mode_d   = mode_q;
    in_sh_d  = in_sh_q;
    out_sh_d = out_sh_q;
    done_d   = 1'b0;
    dout_d   = dout_q;
    err_d    = err_q;
    if (En) begin
      cy_d   = cy_next;
      mode_d = m_eff;
      for (int unsigned i = 0; i < SW; i++) begin
        if (cnt_q == CW'(i)) begin
          in_sh_d[i]  = X;
          out_sh_d[i] = z_raw;
        end
      end
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
        dout_d = out_full;
        if (m_eff) begin
          err_d = (in_full < OFF_V) || (in_full > HI_V);
        end else begin
          err_d = (in_full > RMAX_V);
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      mode_q   <= 1'b0;
      in_sh_q  <= '0;
      out_sh_q <= '0;
      done_q   <= 1'b0;
      dout_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      mode_q   <= mode_d;
      in_sh_q  <= in_sh_d;
      out_sh_q <= out_sh_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
    end
  end

  assign DigitDone = done_q;
  assign Dout      = dout_q;
  assign Err       = err_q;

`ifdef CONV_REG_OUT_EN
  logic z_q;

  // Registered serial output: captures the bit computed on each enabled cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      z_q <= 1'b0;
    end else if (fire) begin
      z_q <= z_raw;
    end
  end

  assign Z = z_q;
`else
  assign Z = fire ? z_raw : 1'b0;
`endif

endmodule

// File: tb/tb_serial_code_converter.sv
// Self-checking bench for serial_code_converter (NBITS=4, OFFSET=3, RANGE=10).
module tb_serial_code_converter;

  localparam int unsigned NB  = 4;
  localparam int unsigned OFF = 3;
  localparam int unsigned RNG = 10;

`ifdef CONV_REG_OUT_EN
  localparam bit REGZ = 1'b1;
`else
  localparam bit REGZ = 1'b0;
`endif

  logic          Clk;
  logic          Rst;
  logic          En;
  logic          Mode;
  logic          X;
  logic          Z;
  logic          DigitDone;
  logic [NB-1:0] Dout;
  logic          Err;

  int checks;
  int errors;

  logic          last_z;
  logic [NB-1:0] last_dout;
  logic          last_err;

  typedef struct {
    logic          md;
    logic [NB-1:0] v;
    logic [NB-1:0] exp_r;
    logic          exp_e;
  } vec_t;

  vec_t vecs [4];

  serial_code_converter #(.NBITS(NB), .OFFSET(OFF), .RANGE(RNG)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .En        (En),
    .Mode      (Mode),
    .X         (X),
    .Z         (Z),
    .DigitDone (DigitDone),
    .Dout      (Dout),
    .Err       (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the digit value plus or minus OFFSET modulo 2**NB, with a range check.
  function automatic void model(input logic md, input logic [NB-1:0] v,
                                output logic [NB-1:0] r, output logic e);
    if (md) begin
      r = NB'(int'(v) - int'(OFF));
      e = (int'(v) < int'(OFF)) || (int'(v) > int'(OFF + RNG - 1));
    end else begin
      r = NB'(int'(v) + int'(OFF));
      e = (int'(v) > int'(RNG - 1));
    end
  endfunction

  // Stream nbits bits of digit v, optionally stalling before bit stall_before.
  task automatic send_digit(input logic md, input logic [NB-1:0] v,
                            input logic [NB-1:0] exp_r, input logic exp_e,
                            input int nbits, input int stall_before,
                            input int stall_len, input bit toggle);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_before) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge Clk);
          En   = 1'b0;
          X    = 1'($urandom);
          Mode = 1'($urandom);
          #1;
          chk("stall_z", 32'(Z), 32'(REGZ ? last_z : 1'b0));
          @(posedge Clk);
          #1;
          chk("stall_done", 32'(DigitDone), 32'(0));
          chk("stall_dout", 32'(Dout), 32'(last_dout));
        end
      end
      @(negedge Clk);
      En   = 1'b1;
      X    = v[i];
      Mode = (i == 0) ? md : (toggle ? ~md : 1'($urandom));
      #1;
      chk("z", 32'(Z), 32'(REGZ ? last_z : exp_r[i]));
      last_z = exp_r[i];
      @(posedge Clk);
      #1;
      if (i == int'(NB) - 1) begin
        chk("done", 32'(DigitDone), 32'(1));
        chk("dout", 32'(Dout), 32'(exp_r));
        chk("err", 32'(Err), 32'(exp_e));
        last_dout = exp_r;
        last_err  = exp_e;
      end else begin
        chk("no_done", 32'(DigitDone), 32'(0));
        chk("dout_hold", 32'(Dout), 32'(last_dout));
        chk("err_hold", 32'(Err), 32'(last_err));
      end
    end
  endtask

  // One-cycle synchronous reset with an active enabled bit presented.
  task automatic pulse_reset();
    @(negedge Clk);
    Rst  = 1'b0;
    En   = 1'b1;
    X    = 1'b1;
    Mode = 1'b1;
    #1;
    if (!REGZ) chk("rst_z_comb", 32'(Z), 32'(0));
    @(posedge Clk);
    #1;
    chk("rst_done", 32'(DigitDone), 32'(0));
    chk("rst_dout", 32'(Dout), 32'(0));
    chk("rst_err", 32'(Err), 32'(0));
    chk("rst_z", 32'(Z), 32'(0));
    @(negedge Clk);
    Rst       = 1'b1;
    En        = 1'b0;
    last_z    = 1'b0;
    last_dout = '0;
    last_err  = 1'b0;
  endtask

  initial begin
    logic [NB-1:0] r;
    logic          e;
    logic [NB-1:0] v;
    logic          md;
    int            sb;

    checks    = 0;
    errors    = 0;
    last_z    = 1'b0;
    last_dout = '0;
    last_err  = 1'b0;

    vecs[0] = '{md: 1'b1, v: 4'd5,  exp_r: 4'b0010, exp_e: 1'b0};
    vecs[1] = '{md: 1'b1, v: 4'd12, exp_r: 4'b1001, exp_e: 1'b0};
    vecs[2] = '{md: 1'b1, v: 4'd1,  exp_r: 4'b1110, exp_e: 1'b1};
    vecs[3] = '{md: 1'b0, v: 4'd7,  exp_r: 4'b1010, exp_e: 1'b0};

    Rst  = 1'b0;
    En   = 1'b0;
    Mode = 1'b0;
    X    = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("init_done", 32'(DigitDone), 32'(0));
    chk("init_dout", 32'(Dout), 32'(0));
    chk("init_err", 32'(Err), 32'(0));
    chk("init_z", 32'(Z), 32'(0));
    @(negedge Clk);
    Rst = 1'b1;

    // Directed digits from the table.
    for (int t = 0; t < 4; t++) begin
      send_digit(vecs[t].md, vecs[t].v, vecs[t].exp_r, vecs[t].exp_e, int'(NB), -1, 0, 1'b0);
    end

    // Two bits of a digit, reset, then a clean digit 0110 in subtract mode.
    model(1'b1, 4'd5, r, e);
    send_digit(1'b1, 4'd5, r, e, 2, -1, 0, 1'b0);
    pulse_reset();
    send_digit(1'b1, 4'd6, 4'b0011, 1'b0, int'(NB), -1, 0, 1'b0);

    // Stall three cycles between bits 1 and 2 while Mode toggles on later bits.
    send_digit(1'b1, 4'd5, 4'b0010, 1'b0, int'(NB), 2, 3, 1'b1);

    // Random back-to-back digits with random stalls and mid-digit Mode noise.
    for (int n = 0; n < 300; n++) begin
      md = 1'($urandom);
      v  = NB'($urandom);
      sb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
      model(md, v, r, e);
      send_digit(md, v, r, e, int'(NB), sb, int'($urandom_range(1, 3)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
